dft_bin_acc: RTL and testbench

DFT_BIN_ACC -- requirements
Module: dft_bin_acc

---
 rtl/dft_pkg.sv | 22 ++
 rtl/dft_cmul.sv | 55 +++++
 rtl/dft_bin_acc.sv | 140 ++++++++++++++
 tb/tb_dft_bin_acc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dft_pkg.sv
// Shared sizes, FSM state encoding and complex result type for the single-bin DFT accumulator.
// Defaults: 64-point frame, Q1.15 twiddles, 16-bit samples, accumulator sized so no input can overflow it.
package dft_pkg;

  localparam int DFT_N  = 64;
  localparam int DFT_SW = 16;
  localparam int DFT_XW = 16;
  localparam int DFT_AW = DFT_SW + DFT_XW + $clog2(DFT_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dft_state_e;

  typedef struct packed {
    logic signed [DFT_AW-1:0] re;
    logic signed [DFT_AW-1:0] im;
  } dft_cplx_t;

endpackage

// File: rtl/dft_cmul.sv
// Registered x * e^(-j*theta): pr = x*cos, pi = -(x*sin), full precision, 1-cycle latency.
// No backpressure: products load only when en_i is high, vld_o follows en_i by one cycle.
module dft_cmul #(
  parameter int SW = 16,
  parameter int XW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic signed [XW-1:0]    x_i,
  input  logic signed [SW-1:0]    sin_i,
  input  logic signed [SW-1:0]    cos_i,
  output logic signed [SW+XW-1:0] pr_o,
  output logic signed [SW+XW-1:0] pi_o,
  output logic                    vld_o
);

  localparam int PW = SW + XW;

  logic signed [PW-1:0] x_ext, sin_ext, cos_ext;
  logic signed [PW-1:0] pr_d, pr_q, pi_d, pi_q;
  logic                 vld_d, vld_q;

  // Operands widened to the product width so the multiply is exact in PW bits.
  assign x_ext   = $signed({{SW{x_i[XW-1]}}, x_i});
  assign sin_ext = $signed({{XW{sin_i[SW-1]}}, sin_i});
  assign cos_ext = $signed({{XW{cos_i[SW-1]}}, cos_i});

  always_comb begin
    pr_d  = pr_q;
    pi_d  = pi_q;
    vld_d = en_i;
    if (en_i) begin
      pr_d = x_ext * cos_ext;
      pi_d = -(x_ext * sin_ext);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr_q  <= '0;
      pi_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      pr_q  <= pr_d;
      pi_q  <= pi_d;
      vld_q <= vld_d;
    end
  end

  assign pr_o  = pr_q;
  assign pi_o  = pi_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/dft_bin_acc.sv
// Single-bin DFT: accumulates x[n]*e^(-j*2*pi*k*n/N) over one N-sample frame; result 3 cycles after the Nth accept.
// Samples stall when x_val_i or tw_val_i is low; the result is held in DONE until res_rdy_i.
module dft_bin_acc
  import dft_pkg::*;
#(
  parameter int N  = DFT_N,
  parameter int SW = DFT_SW,
  parameter int XW = DFT_XW,
  parameter int AW = SW + XW + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic signed [XW-1:0] x_i,
  input  logic                 x_val_i,
  input  logic signed [SW-1:0] sin_i,
  input  logic signed [SW-1:0] cos_i,
  input  logic                 tw_val_i,
  output logic signed [AW-1:0] re_o,
  output logic signed [AW-1:0] im_o,
  output logic                 res_val_o,
  input  logic                 res_rdy_i,
  output logic                 busy_o
);

  localparam int PW = SW + XW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  dft_state_e           state_d, state_q;
  logic [CW-1:0]        cnt_d, cnt_q;
  logic                 drain_d, drain_q;
  logic signed [AW-1:0] acc_re_d, acc_re_q, acc_im_d, acc_im_q;
  logic signed [AW-1:0] re_d, re_q, im_d, im_q;
  logic                 res_val_d, res_val_q;

  logic                 accept;
  logic signed [PW-1:0] pr, pi;
  logic                 p_vld;

  assign accept = (state_q == ACC) && x_val_i && tw_val_i;

  dft_cmul #(
    .SW (SW),
    .XW (XW)
  ) u_cmul (
    .clk   (clk),
    .rst   (rst),
    .en_i  (accept),
    .x_i   (x_i),
    .sin_i (sin_i),
    .cos_i (cos_i),
    .pr_o  (pr),
    .pi_o  (pi),
    .vld_o (p_vld)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    acc_re_d  = acc_re_q;
    acc_im_d  = acc_im_q;
    re_d      = re_q;
    im_d      = im_q;
    res_val_d = res_val_q;

    // Stage 2 runs in ACC and in the first DRAIN cycle, when the last product lands.
    if (p_vld) begin
      acc_re_d = acc_re_q + $signed({{(AW-PW){pr[PW-1]}}, pr});
      acc_im_d = acc_im_q + $signed({{(AW-PW){pi[PW-1]}}, pi});
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = ACC;
          cnt_d    = '0;
          acc_re_d = '0;
          acc_im_d = '0;
        end
      end
      ACC: begin
        if (accept) begin
          if (cnt_q == CW'(N-1)) begin
            cnt_d   = '0;
            drain_d = 1'b0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d   = DONE;
          res_val_d = 1'b1;
          re_d      = acc_re_q;
          im_d      = acc_im_q;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        if (res_rdy_i) begin
          state_d   = IDLE;
          res_val_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      re_q      <= '0;
      im_q      <= '0;
      res_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      acc_re_q  <= acc_re_d;
      acc_im_q  <= acc_im_d;
      re_q      <= re_d;
      im_q      <= im_d;
      res_val_q <= res_val_d;
    end
  end

  assign re_o      = re_q;
  assign im_o      = im_q;
  assign res_val_o = res_val_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_dft_bin_acc.sv
// Randomized and directed frames against a plain-arithmetic DFT bin model.
// Checks latency, hold-in-DONE, start masking and mid-frame reset.
module tb_dft_bin_acc;
  import dft_pkg::*;

  localparam int N  = DFT_N;
  localparam int SW = DFT_SW;
  localparam int XW = DFT_XW;
  localparam int AW = DFT_AW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start_i = 1'b0;
  logic signed [XW-1:0] x_i = '0;
  logic                 x_val_i = 1'b0;
  logic signed [SW-1:0] sin_i = '0;
  logic signed [SW-1:0] cos_i = '0;
  logic                 tw_val_i = 1'b0;
  logic signed [AW-1:0] re_o, im_o;
  logic                 res_val_o;
  logic                 res_rdy_i = 1'b0;
  logic                 busy_o;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  int hs_cnt = 0;
  int xs[N];
  int cs[N];
  int ss[N];

  dft_bin_acc dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .x_i       (x_i),
    .x_val_i   (x_val_i),
    .sin_i     (sin_i),
    .cos_i     (cos_i),
    .tw_val_i  (tw_val_i),
    .re_o      (re_o),
    .im_o      (im_o),
    .res_val_o (res_val_o),
    .res_rdy_i (res_rdy_i),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (busy_o) busy_cnt <= busy_cnt + 1;
    if (res_val_o && res_rdy_i) hs_cnt <= hs_cnt + 1;
  end

  task automatic check_val(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input int xv, input int cv, input int sv);
    for (int i = 0; i < N; i++) begin
      xs[i] = xv;
      cs[i] = cv;
      ss[i] = sv;
    end
  endtask

  function automatic int rand16();
    logic signed [15:0] t;
    if ($urandom_range(0, 7) == 0) t = -16'sd32768;
    else t = 16'($urandom);
    return int'(t);
  endfunction

  task automatic fill_rand;
    for (int i = 0; i < N; i++) begin
      xs[i] = rand16();
      cs[i] = rand16();
      ss[i] = rand16();
    end
  endtask

  // vmode 0: both valids always high; 1: x_val toggles; 2: random gaps on both.
  task automatic run_frame(input string tag, input int vmode, input int hold, output int busy_len);
    longint er = 0;
    longint ei = 0;
    int     idx = 0;
    int     cyc = 0;
    bit     tog = 1'b1;
    logic   vx, vt;
    for (int i = 0; i < N; i++) begin
      er += longint'(xs[i]) * longint'(cs[i]);
      ei -= longint'(xs[i]) * longint'(ss[i]);
    end
    busy_cnt = 0;
    hs_cnt   = 0;
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
    while (idx < N && cyc < 4000) begin
      case (vmode)
        0:       begin vx = 1'b1; vt = 1'b1; end
        1:       begin vx = tog; vt = 1'b1; tog = ~tog; end
        default: begin vx = ($urandom_range(0, 3) != 0); vt = ($urandom_range(0, 3) != 0); end
      endcase
      x_val_i  = vx;
      tw_val_i = vt;
      x_i   = vx ? XW'(xs[idx]) : XW'($urandom);
      cos_i = vt ? SW'(cs[idx]) : SW'($urandom);
      sin_i = vt ? SW'(ss[idx]) : SW'($urandom);
      tick();
      cyc++;
      if (vx && vt) idx++;
    end
    check_val({tag, "_accepted"}, longint'(idx), longint'(N));
    x_val_i  = 1'b0;
    tw_val_i = 1'b0;
    check_val({tag, "_val_lat1"}, longint'(res_val_o), 0);
    tick();
    check_val({tag, "_val_lat2"}, longint'(res_val_o), 0);
    tick();
    check_val({tag, "_val_lat3"}, longint'(res_val_o), 1);
    check_val({tag, "_re"}, longint'(re_o), er);
    check_val({tag, "_im"}, longint'(im_o), ei);
    for (int h = 0; h < hold; h++) begin
      start_i   = (h % 3 == 0);
      res_rdy_i = 1'b0;
      tick();
      check_val({tag, "_hold_val"}, longint'(res_val_o), 1);
      check_val({tag, "_hold_re"}, longint'(re_o), er);
      check_val({tag, "_hold_im"}, longint'(im_o), ei);
    end
    start_i   = 1'b1;
    res_rdy_i = 1'b1;
    tick();
    start_i   = 1'b0;
    res_rdy_i = 1'b0;
    check_val({tag, "_val_drop"}, longint'(res_val_o), 0);
    check_val({tag, "_idle_busy"}, longint'(busy_o), 0);
    check_val({tag, "_handshakes"}, longint'(hs_cnt), 1);
    busy_len = busy_cnt;
    // Stray valids in IDLE must not disturb anything, and the result must persist.
    x_val_i  = 1'b1;
    tw_val_i = 1'b1;
    x_i      = XW'($urandom);
    tick();
    x_val_i  = 1'b0;
    tw_val_i = 1'b0;
    tick();
    check_val({tag, "_idle_busy2"}, longint'(busy_o), 0);
    check_val({tag, "_keep_re"}, longint'(re_o), er);
    check_val({tag, "_keep_im"}, longint'(im_o), ei);
  endtask

  initial begin
    int bl;
    #1 rst = 1'b1;
    tick();
    tick();
    check_val("rst_re", longint'(re_o), 0);
    check_val("rst_im", longint'(im_o), 0);
    check_val("rst_val", longint'(res_val_o), 0);
    check_val("rst_busy", longint'(busy_o), 0);
    rst = 1'b0;
    tick();

    fill_const(1000, 32767, 0);
    run_frame("cos_frame", 0, 0, bl);
    check_val("cos_frame_busy_len", longint'(bl), longint'(N + 3));

    fill_const(1000, 0, 16384);
    run_frame("sin_frame", 0, 0, bl);

    fill_const(-32768, -32768, -32768);
    run_frame("extreme_frame", 0, 0, bl);

    fill_const(1000, 32767, 0);
    run_frame("toggle_frame", 1, 0, bl);
    check_val("toggle_busy_range", longint'(bl >= 128 && bl <= 134), 1);

    run_frame("hold_frame", 0, 10, bl);

    // Abort a frame after 20 accepted samples.
    start_i = 1'b1;
    tick();
    start_i  = 1'b0;
    x_val_i  = 1'b1;
    tw_val_i = 1'b1;
    x_i      = 16'sd1000;
    cos_i    = 16'sd32767;
    sin_i    = 16'sd0;
    for (int i = 0; i < 20; i++) tick();
    check_val("midrst_busy_before", longint'(busy_o), 1);
    rst = 1'b1;
    #2;
    check_val("midrst_re", longint'(re_o), 0);
    check_val("midrst_im", longint'(im_o), 0);
    check_val("midrst_val", longint'(res_val_o), 0);
    check_val("midrst_busy", longint'(busy_o), 0);
    x_val_i  = 1'b0;
    tw_val_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_val("midrst_busy_after", longint'(busy_o), 0);
    run_frame("post_rst_frame", 0, 0, bl);

    for (int f = 0; f < 6; f++) begin
      fill_rand();
      run_frame($sformatf("rand%0d", f), 2, $urandom_range(0, 4), bl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
